route_shift_stage: RTL and testbench
====================================

// Module: route_shift_stage
// PURPOSE
//  Clocked, parametrised successor of the router's combinational header left-shift.
//  Consumes one routing-address bit-group per hop on the header flit of each packet.
//  Body flits pass through unchanged; a DEPTH-entry buffer decouples the upstream and downstream handshakes.
//  Sits between the input port and the crossbar arbiter of each router node.
// PARAMETERS
//  WIDTH   11  flit width in bits
//  SHIFT   1   bits consumed per hop (1..WIDTH-1)
//  DEPTH   2   buffer entries; power of two, >=2
//  ROTATE  0   0: shift left, zero fill; 1: rotate left (vacated LSBs take the ejected MSBs)
// PORTS
//  clk        in   1                    rising-edge clock
//  reset      in   1                    asynchronous, active-high reset
//  in_valid   in   1                    upstream flit valid
//  in_ready   out  1                    stage can accept a flit
//  in_data    in   WIDTH                upstream flit
//  in_last    in   1                    tail flit of packet (a head with in_last=1 is a single-flit packet)
//  out_valid  out  1                    buffered flit available
//  out_ready  in   1                    downstream accepts
//  out_data   out  WIDTH                flit at buffer head
//  out_last   out  1                    tail marker of out_data
//  level      out  $clog2(DEPTH+1)      current buffer occupancy
// BEHAVIOUR
//  Reset (async assert, sync deassert by design):
//   - state=HEAD; count and pointers cleared; storage cleared.
//   - out_valid=0, out_data=0, out_last=0, level=0, in_ready=1.
//  Handshake:
//   - transfer when valid&&ready at the rising edge of clk.
//   - valid must not depend on ready; data and last stay stable while valid&&!ready.
//   - in_ready = (count!=DEPTH); registered-state only, no combinational path from out_ready.
//  Transform, applied at push:
//   - state=HEAD:   stored = ROTATE ? {d[WIDTH-SHIFT-1:0], d[WIDTH-1:WIDTH-SHIFT]} : {d[WIDTH-SHIFT-1:0], SHIFT'b0}
//   - state=BODY:   stored = d, unchanged.
//   - in_last is stored unchanged alongside the data.
//  FSM, advances only on input transfer:
//   - HEAD -> BODY on push with in_last=0.
//   - HEAD -> HEAD on push with in_last=1.
//   - BODY -> HEAD on push with in_last=1.
//   - otherwise hold.
//  Latency and throughput:
//   - pushed flit visible on out_valid/out_data the cycle after transfer (1-cycle latency).
//   - one flit per cycle sustained when out_ready=1.
//  Buffer:
//   - circular, wr/rd pointers of $clog2(DEPTH) bits; wrap from DEPTH-1 to 0.
//   - push and pop in the same cycle leave count unchanged; legal whenever count in 1..DEPTH-1.
//   - count=DEPTH forces in_ready=0, even if out_ready=1 that cycle.
//   - empty: out_valid=0; out_data/out_last are don't-care.
//   - level = count.
//   - order is strictly FIFO; no flit is dropped or duplicated.
//  Reset mid-packet:
//   - buffered flits are discarded.
//   - FSM returns to HEAD, so the next accepted flit is treated as a header.
// STRUCTURE
//  - Shared include router_defs.v: FSM state encodings (ST_HEAD, ST_BODY), default flit width, SHIFT/ROTATE defaults.
//  - One sub-module: sync_fifo (WIDTH+1 bits x DEPTH, push/pop/full/empty/count). The top level holds the FSM and shift logic.
// TESTING (WIDTH=11, SHIFT=1, DEPTH=2 unless noted)
//  1. Single-flit head 11'b01010100111, last=1, out_ready=1 -> out 11'b10101001110 one cycle later; state stays HEAD.
//  2. 3-flit packet: head 11'b11011100100, bodies 11'h2A5, 11'h013 (last) -> 11'b10111001000, 11'h2A5, 11'h013 with out_last only on the third.
//  3. ROTATE=1: head 11'b11011100100 -> 11'b10111001001.
//  4. out_ready=0, push 3 flits -> in_ready low after 2 accepts, level=2; release -> order preserved and 3rd flit accepted.
//  5. Continuous stream, out_ready=1, DEPTH=4, 10 flits -> 1 flit/cycle, pointers wrap, level never exceeds 1.
//  6. Assert reset after the head of a 2-flit packet -> out_valid=0, level=0 immediately; next flit 11'h401 shifted to 11'h002.

Source files
------------

// File: rtl/route_shift_stage_pkg.sv
// Shared definitions for the router header-shift stage: FSM encodings,
// default geometry and the circular-buffer pointer helper.
package route_shift_stage_pkg;

    localparam int DEF_WIDTH  = 11;
    localparam int DEF_SHIFT  = 1;
    localparam int DEF_DEPTH  = 2;
    localparam int DEF_ROTATE = 0;

    typedef enum logic [0:0] {
        ST_HEAD = 1'b0,
        ST_BODY = 1'b1
    } state_e;

    // Circular pointer advance; explicit wrap keeps non-power-of-two reuse safe.
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        int unsigned nxt;
        if (ptr == depth - 32'd1) begin
            nxt = 32'd0;
        end else begin
            nxt = ptr + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/route_shift_stage_sync_fifo.sv
// Circular synchronous FIFO holding {last, flit} entries for the shift stage.
// Push is ignored when full and pop when empty, so callers may drive raw requests.
module route_shift_stage_sync_fifo
    import route_shift_stage_pkg::*;
#(
    parameter int DW    = 12,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [DW-1:0]              i_wr_data,
    output logic [DW-1:0]              o_rd_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_empty;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == {CW{1'b0}});
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !w_empty;

    // Storage and write pointer; storage is cleared so the reset head reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {DW{1'b0}};
            end
            r_wr_ptr <= {PW{1'b0}};
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
            r_wr_ptr        <= PW'(ptr_next(32'(r_wr_ptr), DEPTH));
        end
    end

    // Read pointer advances on every accepted pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= {PW{1'b0}};
        end else if (w_do_pop) begin
            r_rd_ptr <= PW'(ptr_next(32'(r_rd_ptr), DEPTH));
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= {CW{1'b0}};
        end else begin
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_count   = r_count;

endmodule

// File: rtl/route_shift_stage.sv
// Router hop stage: consumes SHIFT address bits from each packet header at push
// time and buffers flits in a DEPTH-entry FIFO between upstream and crossbar.
module route_shift_stage
    import route_shift_stage_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SHIFT  = DEF_SHIFT,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ROTATE = DEF_ROTATE
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_last,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_rot;
    logic [WIDTH-1:0] w_head;
    logic [WIDTH-1:0] w_store;
    logic [WIDTH:0]   w_fifo_din;
    logic [WIDTH:0]   w_fifo_dout;

    // Full/empty come from the registered count only, so in_ready never sees out_ready.
    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && !w_full;
    assign w_pop     = out_ready && !w_empty;

    assign w_shl = {in_data[WIDTH-SHIFT-1:0], {SHIFT{1'b0}}};
    assign w_rot = {in_data[WIDTH-SHIFT-1:0], in_data[WIDTH-1:WIDTH-SHIFT]};

    // Select the header transform and apply it only to the first flit of a packet.
    always_comb begin
        w_head  = w_shl;
        w_store = in_data;
        if (ROTATE != 0) begin
            w_head = w_rot;
        end else begin
            w_head = w_shl;
        end
        if (r_state == ST_HEAD) begin
            w_store = w_head;
        end else begin
            w_store = in_data;
        end
    end

    assign w_fifo_din = {in_last, w_store};

    // Packet-position state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_HEAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: a tail returns to HEAD, a non-tail header moves to BODY.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_HEAD: begin
                if (w_push && !in_last) begin
                    w_state_nxt = ST_BODY;
                end else begin
                    w_state_nxt = ST_HEAD;
                end
            end
            ST_BODY: begin
                if (w_push && in_last) begin
                    w_state_nxt = ST_HEAD;
                end else begin
                    w_state_nxt = ST_BODY;
                end
            end
            default: w_state_nxt = ST_HEAD;
        endcase
    end

    route_shift_stage_sync_fifo #(
        .DW    (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_wr_data (w_fifo_din),
        .o_rd_data (w_fifo_dout),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (level)
    );

    assign out_data = w_fifo_dout[WIDTH-1:0];
    assign out_last = w_fifo_dout[WIDTH];

endmodule

// File: tb/tb_route_shift_stage.sv
// Directed bench for route_shift_stage: default geometry, rotate variant and a
// DEPTH=4 instance, each checked against hand-computed flit values.
module tb_route_shift_stage;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    // Instance A: WIDTH=11, SHIFT=1, DEPTH=2, shift mode
    logic        a_in_valid = 1'b0, a_in_last = 1'b0, a_out_ready = 1'b0;
    logic [10:0] a_in_data = 11'd0;
    logic        a_in_ready, a_out_valid, a_out_last;
    logic [10:0] a_out_data;
    logic [1:0]  a_level;

    // Instance B: rotate mode
    logic        b_in_valid = 1'b0, b_in_last = 1'b0, b_out_ready = 1'b0;
    logic [10:0] b_in_data = 11'd0;
    logic        b_in_ready, b_out_valid, b_out_last;
    logic [10:0] b_out_data;
    logic [1:0]  b_level;

    // Instance C: DEPTH=4
    logic        c_in_valid = 1'b0, c_in_last = 1'b0, c_out_ready = 1'b0;
    logic [10:0] c_in_data = 11'd0;
    logic        c_in_ready, c_out_valid, c_out_last;
    logic [10:0] c_out_data;
    logic [2:0]  c_level;

    route_shift_stage dut_a (
        .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_last(a_in_last), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .out_last(a_out_last),
        .level(a_level)
    );

    route_shift_stage #(.ROTATE(1)) dut_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_last(b_in_last), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last),
        .level(b_level)
    );

    route_shift_stage #(.DEPTH(4)) dut_c (
        .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_last(c_in_last), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_data(c_out_data), .out_last(c_out_last),
        .level(c_level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [10:0] exp_d;

        // Reset state while reset is held
        #1;
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_data",  32'(a_out_data),  32'd0);
        chk("rst_out_last",  32'(a_out_last),  32'd0);
        chk("rst_level",     32'(a_level),     32'd0);
        chk("rst_in_ready",  32'(a_in_ready),  32'd1);
        tick();
        tick();
        reset = 1'b0;

        // 1: single-flit header
        a_out_ready = 1'b1;
        a_in_valid = 1'b1; a_in_data = 11'b01010100111; a_in_last = 1'b1;
        tick();
        a_in_valid = 1'b0;
        chk("t1_valid", 32'(a_out_valid), 32'd1);
        chk("t1_data",  32'(a_out_data),  32'(11'b10101001110));
        chk("t1_last",  32'(a_out_last),  32'd1);
        chk("t1_level", 32'(a_level),     32'd1);
        tick();
        chk("t1_drain", 32'(a_out_valid), 32'd0);

        // 2: three-flit packet, header only transformed
        a_in_valid = 1'b1; a_in_data = 11'b11011100100; a_in_last = 1'b0;
        tick();
        chk("t2_head",      32'(a_out_data), 32'(11'b10111001000));
        chk("t2_head_last", 32'(a_out_last), 32'd0);
        a_in_data = 11'h2A5; a_in_last = 1'b0;
        tick();
        chk("t2_body1",      32'(a_out_data), 32'(11'h2A5));
        chk("t2_body1_last", 32'(a_out_last), 32'd0);
        chk("t2_level",      32'(a_level),    32'd1);
        a_in_data = 11'h013; a_in_last = 1'b1;
        tick();
        chk("t2_tail",      32'(a_out_data), 32'(11'h013));
        chk("t2_tail_last", 32'(a_out_last), 32'd1);
        a_in_valid = 1'b0;
        tick();
        chk("t2_drain", 32'(a_out_valid), 32'd0);

        // 3: rotate variant
        b_out_ready = 1'b1;
        b_in_valid = 1'b1; b_in_data = 11'b11011100100; b_in_last = 1'b1;
        tick();
        b_in_valid = 1'b0;
        chk("t3_rot_valid", 32'(b_out_valid), 32'd1);
        chk("t3_rot_data",  32'(b_out_data),  32'(11'b10111001001));

        // 4: backpressure, full buffer, order preserved
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 11'h101; a_in_last = 1'b0;
        tick();
        chk("t4_lvl1",   32'(a_level),    32'd1);
        chk("t4_rdy1",   32'(a_in_ready), 32'd1);
        a_in_data = 11'h055; a_in_last = 1'b0;
        tick();
        chk("t4_lvl2",   32'(a_level),    32'd2);
        chk("t4_rdy2",   32'(a_in_ready), 32'd0);
        a_in_data = 11'h066; a_in_last = 1'b1;
        tick();
        chk("t4_hold_lvl",  32'(a_level),    32'd2);
        chk("t4_hold_data", 32'(a_out_data), 32'(11'h202));
        a_out_ready = 1'b1;
        #1;
        chk("t4_full_rdy", 32'(a_in_ready), 32'd0);
        tick();
        chk("t4_pop_lvl",  32'(a_level),    32'd1);
        chk("t4_pop_data", 32'(a_out_data), 32'(11'h055));
        chk("t4_pop_rdy",  32'(a_in_ready), 32'd1);
        tick();
        chk("t4_c_lvl",  32'(a_level),    32'd1);
        chk("t4_c_data", 32'(a_out_data), 32'(11'h066));
        chk("t4_c_last", 32'(a_out_last), 32'd1);
        a_in_valid = 1'b0;
        tick();
        chk("t4_drain", 32'(a_out_valid), 32'd0);

        // 5: continuous stream through DEPTH=4 instance
        c_out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            c_in_valid = 1'b1;
            c_in_data  = 11'h100 + 11'(i);
            c_in_last  = (i == 9);
            tick();
            exp_d = (i == 0) ? 11'h200 : (11'h100 + 11'(i));
            chk("t5_valid", 32'(c_out_valid), 32'd1);
            chk("t5_data",  32'(c_out_data),  32'(exp_d));
            chk("t5_last",  32'(c_out_last),  32'(i == 9));
            chk("t5_level", 32'(c_level),     32'd1);
            chk("t5_rdy",   32'(c_in_ready),  32'd1);
        end
        c_in_valid = 1'b0;
        tick();
        chk("t5_drain", 32'(c_level), 32'd0);

        // 6: reset after the header of a two-flit packet
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 11'h123; a_in_last = 1'b0;
        tick();
        a_in_valid = 1'b0;
        chk("t6_pre_lvl", 32'(a_level), 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(a_out_valid), 32'd0);
        chk("t6_rst_level", 32'(a_level),     32'd0);
        tick();
        reset = 1'b0;
        a_out_ready = 1'b1;
        a_in_valid = 1'b1; a_in_data = 11'h401; a_in_last = 1'b1;
        tick();
        a_in_valid = 1'b0;
        chk("t6_new_head", 32'(a_out_data), 32'(11'h002));
        chk("t6_new_last", 32'(a_out_last), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
